fsab_sim_mem_param: RTL and testbench

- Parametrised, fully functional FSAB slave memory model for simulation; next generation of the FSAB simulation memory.
- Queues inbound FSAB requests and write data, then executes reads and writes in order against an internal word array.
- Returns read data on the fsabi channel after a programmable latency, and returns one credit per retired request.
- Sits on the FSAB bus in place of the DDR controller in testbenches.

---
 rtl/fsab_sim_mem_param.sv | 258 +++++++++++++++++++++++++
 tb/tb_fsab_sim_mem_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_sim_mem_param.sv
// FSAB slave memory model for simulation: queues requests and write data,
// executes them in order against a word array and returns read data and credits.
module fsab_sim_mem_param #(
  parameter int DATA_W    = 64,
  parameter int MASK_W    = DATA_W / 8,
  parameter int ADDR_W    = 31,
  parameter int LEN_W     = 4,
  parameter int LEN_MAX   = 8,
  parameter int DID_W     = 4,
  parameter int CREDITS   = 4,
  parameter int MEM_WORDS = 65536,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              fsabo_valid,
  input  logic              fsabo_mode,
  input  logic [DID_W-1:0]  fsabo_did,
  input  logic [DID_W-1:0]  fsabo_subdid,
  input  logic [ADDR_W-1:0] fsabo_addr,
  input  logic [LEN_W-1:0]  fsabo_len,
  input  logic [DATA_W-1:0] fsabo_data,
  input  logic [MASK_W-1:0] fsabo_mask,
  output logic              fsabo_credit,
  output logic              fsabi_valid,
  output logic [DID_W-1:0]  fsabi_did,
  output logic [DID_W-1:0]  fsabi_subdid,
  output logic [DATA_W-1:0] fsabi_data,
  output logic              err
);

  localparam int OFF_W    = $clog2(MASK_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int RQ_AW    = $clog2(CREDITS);
  localparam int RQ_PW    = RQ_AW + 1;
  localparam int DQ_DEPTH = CREDITS * LEN_MAX;
  localparam int DQ_AW    = $clog2(DQ_DEPTH);
  localparam int DQ_PW    = DQ_AW + 1;
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int RQ_W     = 1 + 2 * DID_W + IDX_W + LEN_W;
  localparam int DQ_W     = DATA_W + MASK_W;

  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);
  localparam logic [LEN_W:0]   LEN_MAX_C = (LEN_W + 1)'(LEN_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_WRITE} state_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [MASK_W-1:0] m);
    merge_bytes = old_w;
    for (int b = 0; b < MASK_W; b++)
      if (m[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
  endfunction

  logic [DATA_W-1:0] mem    [MEM_WORDS];
  logic [RQ_W-1:0]   rq_mem [CREDITS];
  logic [DQ_W-1:0]   dq_mem [DQ_DEPTH];

  logic [RQ_PW-1:0] rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
  logic [DQ_PW-1:0] dq_wptr_q, dq_wptr_d, dq_rptr_q, dq_rptr_d;
  logic [LEN_W-1:0] tracker_q, tracker_d;
  logic             err_q, err_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] beat_q, beat_d, len_q, len_d;
  logic [DID_W-1:0] did_q, did_d, sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic              fsabi_valid_q, fsabi_valid_d, fsabo_credit_q, fsabo_credit_d;
  logic [DID_W-1:0]  fsabi_did_q, fsabi_did_d, fsabi_subdid_q, fsabi_subdid_d;
  logic [DATA_W-1:0] fsabi_data_q, fsabi_data_d;

  logic rq_push, rq_pop, dq_push, dq_pop, rq_empty, rq_full, dq_empty, dq_full;
  logic len_ok, mem_we, wr_done;
  logic [ADDR_W-1:0] addr_word;
  logic [IDX_W-1:0]  in_idx, rd_idx, wr_idx;
  logic [DATA_W-1:0] wr_word, dq_data_h;
  logic [MASK_W-1:0] dq_mask_h;
  logic              h_mode;
  logic [DID_W-1:0]  h_did, h_sub;
  logic [IDX_W-1:0]  h_idx;
  logic [LEN_W-1:0]  h_len;
  logic              unused_addr_hi;

  assign addr_word      = fsabo_addr >> OFF_W;
  assign in_idx         = addr_word[IDX_W-1:0];
  assign unused_addr_hi = ^addr_word[ADDR_W-1:IDX_W];
  assign len_ok         = (fsabo_len != '0) && ({1'b0, fsabo_len} <= LEN_MAX_C);

  assign rq_empty = (rq_wptr_q == rq_rptr_q);
  assign rq_full  = ((rq_wptr_q ^ rq_rptr_q) == RQ_PW'(CREDITS));
  assign dq_empty = (dq_wptr_q == dq_rptr_q);
  assign dq_full  = ((dq_wptr_q ^ dq_rptr_q) == DQ_PW'(DQ_DEPTH));

  assign {h_mode, h_did, h_sub, h_idx, h_len} = rq_mem[rq_rptr_q[RQ_AW-1:0]];
  assign {dq_data_h, dq_mask_h}               = dq_mem[dq_rptr_q[DQ_AW-1:0]];

  // Intake: header/beat classification and FIFO pushes. The executing request
  // stays in the request FIFO until it retires, so occupancy tracks credits.
  always_comb begin
    tracker_d = tracker_q;
    err_d     = err_q;
    rq_push   = 1'b0;
    dq_push   = 1'b0;
    if (fsabo_valid) begin
      if (tracker_q == '0) begin
        if (!len_ok)                              err_d = 1'b1;
        else if (rq_full && !rq_pop)              err_d = 1'b1;
        else if (fsabo_mode && dq_full && !dq_pop) err_d = 1'b1;
        else begin
          rq_push = 1'b1;
          if (fsabo_mode) begin
            dq_push   = 1'b1;
            tracker_d = fsabo_len - LEN_W'(1);
          end
        end
      end else begin
        tracker_d = tracker_q - LEN_W'(1);
        if (dq_full && !dq_pop) err_d = 1'b1;
        else                    dq_push = 1'b1;
      end
    end
    rq_wptr_d = rq_wptr_q + RQ_PW'(rq_push);
    rq_rptr_d = rq_rptr_q + RQ_PW'(rq_pop);
    dq_wptr_d = dq_wptr_q + DQ_PW'(dq_push);
    dq_rptr_d = dq_rptr_q + DQ_PW'(dq_pop);
  end

  assign wr_idx  = idx_q + IDX_W'(beat_q);
  assign wr_word = merge_bytes(mem[wr_idx], dq_data_h, dq_mask_h);

  // Execution FSM; read outputs are computed from the next state so the
  // registered beat lines up with the cycle spent in READ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    did_d   = did_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rq_pop  = 1'b0;
    dq_pop  = 1'b0;
    mem_we  = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rq_empty) begin
          did_d  = h_did;
          sub_d  = h_sub;
          idx_d  = h_idx;
          len_d  = h_len;
          beat_d = '0;
          if (h_mode) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_READ;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ: begin
        if (beat_q == len_q - LEN_W'(1)) begin
          state_d = S_IDLE;
          rq_pop  = 1'b1;
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      S_WRITE: begin
        if (!dq_empty) begin
          dq_pop = 1'b1;
          mem_we = 1'b1;
          if (beat_q == len_q - LEN_W'(1)) begin
            state_d = S_IDLE;
            rq_pop  = 1'b1;
            wr_done = 1'b1;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_idx         = idx_d + IDX_W'(beat_d);
    fsabi_valid_d  = (state_d == S_READ);
    fsabi_did_d    = fsabi_valid_d ? did_d : '0;
    fsabi_subdid_d = fsabi_valid_d ? sub_d : '0;
    fsabi_data_d   = fsabi_valid_d ? mem[rd_idx] : '0;
    fsabo_credit_d = (fsabi_valid_d && (beat_d == len_d - LEN_W'(1))) || wr_done;
  end

  // Storage arrays: no reset, contents survive Nrst.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_idx] <= wr_word;
    if (rq_push) rq_mem[rq_wptr_q[RQ_AW-1:0]] <= {fsabo_mode, fsabo_did, fsabo_subdid, in_idx, fsabo_len};
    if (dq_push) dq_mem[dq_wptr_q[DQ_AW-1:0]] <= {fsabo_data, fsabo_mask};
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      rq_wptr_q      <= '0;
      rq_rptr_q      <= '0;
      dq_wptr_q      <= '0;
      dq_rptr_q      <= '0;
      tracker_q      <= '0;
      err_q          <= 1'b0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      beat_q         <= '0;
      len_q          <= '0;
      did_q          <= '0;
      sub_q          <= '0;
      idx_q          <= '0;
      fsabi_valid_q  <= 1'b0;
      fsabo_credit_q <= 1'b0;
      fsabi_did_q    <= '0;
      fsabi_subdid_q <= '0;
      fsabi_data_q   <= '0;
    end else begin
      rq_wptr_q      <= rq_wptr_d;
      rq_rptr_q      <= rq_rptr_d;
      dq_wptr_q      <= dq_wptr_d;
      dq_rptr_q      <= dq_rptr_d;
      tracker_q      <= tracker_d;
      err_q          <= err_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      beat_q         <= beat_d;
      len_q          <= len_d;
      did_q          <= did_d;
      sub_q          <= sub_d;
      idx_q          <= idx_d;
      fsabi_valid_q  <= fsabi_valid_d;
      fsabo_credit_q <= fsabo_credit_d;
      fsabi_did_q    <= fsabi_did_d;
      fsabi_subdid_q <= fsabi_subdid_d;
      fsabi_data_q   <= fsabi_data_d;
    end
  end

  assign fsabo_credit = fsabo_credit_q;
  assign fsabi_valid  = fsabi_valid_q;
  assign fsabi_did    = fsabi_did_q;
  assign fsabi_subdid = fsabi_subdid_q;
  assign fsabi_data   = fsabi_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fsab_sim_mem_param.sv
// Scoreboard bench for fsab_sim_mem_param: expected read beats are queued when
// requests are driven and matched against beats captured from fsabi.
module tb_fsab_sim_mem_param;
  localparam int LATENCY = 4;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        Nrst = 1'b0;
  logic        fsabo_valid = 1'b0, fsabo_mode = 1'b0;
  logic [3:0]  fsabo_did = '0, fsabo_subdid = '0, fsabo_len = '0;
  logic [30:0] fsabo_addr = '0;
  logic [63:0] fsabo_data = '0;
  logic [7:0]  fsabo_mask = '0;
  logic        fsabo_credit, fsabi_valid, err;
  logic [3:0]  fsabi_did, fsabi_subdid;
  logic [63:0] fsabi_data;

  fsab_sim_mem_param dut (
    .clk(clk), .Nrst(Nrst),
    .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode), .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr), .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data), .fsabo_mask(fsabo_mask), .fsabo_credit(fsabo_credit),
    .fsabi_valid(fsabi_valid), .fsabi_did(fsabi_did), .fsabi_subdid(fsabi_subdid),
    .fsabi_data(fsabi_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  did;
    logic [3:0]  sub;
    logic [63:0] data;
    int          cyc;
    logic        cr;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int cyc = 0, credits = 0, idle_bad = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fsabi_valid) obs_q.push_back('{fsabi_did, fsabi_subdid, fsabi_data, cyc, fsabo_credit});
    if (fsabo_credit) credits <= credits + 1;
    if (!fsabi_valid && fsabi_data !== 64'h0) idle_bad <= idle_bad + 1;
  end

  task automatic drive(input logic v, input logic m, input logic [3:0] did, input logic [3:0] sub,
                       input logic [30:0] addr, input logic [3:0] len, input logic [63:0] data,
                       input logic [7:0] mask);
    fsabo_valid = v; fsabo_mode = m; fsabo_did = did; fsabo_subdid = sub;
    fsabo_addr = addr; fsabo_len = len; fsabo_data = data; fsabo_mask = mask;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    fsabo_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    Nrst = 1'b0;
    #12;
    checks++; if (fsabi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fsabi_valid); end
    checks++; if (fsabo_credit !== 1'b0) begin errors++; $display("FAIL reset_credit: got %b want 0", fsabo_credit); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (fsabi_data !== 64'h0 || fsabi_did !== 4'h0 || fsabi_subdid !== 4'h0) begin
      errors++; $display("FAIL reset_data: got data=%h did=%h sub=%h want 0", fsabi_data, fsabi_did, fsabi_subdid);
    end
    @(posedge clk); #1;
    Nrst = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int c0, t; bit ok; beat_t e, o;
    c0 = credits;
    drive(1, 1, 0, 0, 31'h40, 1, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    idle(10);
    checks++; if (credits !== c0 + 1) begin errors++; $display("FAIL single_wr_credit: got %0d want %0d", credits - c0, 1); end
    t = cyc;
    drive(1, 0, 3, 1, 31'h40, 1, 64'h0, 8'h0);
    exp_q.push_back('{4'd3, 4'd1, 64'hDEADBEEF_CAFEF00D, t + 2 + LATENCY, 1'b1});
    idle(1);
    wait_beats(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got %0d beats want 1", obs_q.size()); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != e.cyc || o.cr !== e.cr) begin
        errors++; $display("FAIL single_rd: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                           o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, e.cyc, e.cr);
      end
    end
    exp_q.delete();
    idle(6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra_beats: got %0d want 0", obs_q.size()); end
    checks++; if (credits !== c0 + 2) begin errors++; $display("FAIL single_credits: got %0d want 2", credits - c0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
    obs_q.delete();
  endtask

  task automatic test_masked_burst();
    int c0, base; bit ok; beat_t e, o;
    logic [63:0] want [4];
    want[0] = 64'h0; want[1] = 64'h1; want[2] = 64'h00000000_FFFFFFFF; want[3] = 64'h3;
    c0 = credits;
    drive(1, 1, 0, 0, 31'h100, 4, 64'h0, 8'hFF);
    drive(1, 1, 0, 0, 31'h0, 0, 64'h1, 8'hFF);
    drive(0, 1, 0, 0, 31'h0, 0, 64'h0, 8'h0);
    drive(1, 1, 0, 0, 31'h0, 0, 64'h2, 8'hFF);
    drive(1, 1, 0, 0, 31'h0, 0, 64'h3, 8'hFF);
    drive(1, 1, 0, 0, 31'h110, 1, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    drive(1, 0, 5, 2, 31'h100, 4, 64'h0, 8'h0);
    for (int k = 0; k < 4; k++) exp_q.push_back('{4'd5, 4'd2, want[k], k, (k == 3)});
    idle(1);
    wait_beats(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL masked_timeout: got %0d beats want 4", obs_q.size()); end
    else begin
      base = obs_q[0].cyc;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != base + e.cyc || o.cr !== e.cr) begin
          errors++; $display("FAIL masked_rd beat %0d: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                             e.cyc, o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, base + e.cyc, e.cr);
        end
      end
    end
    exp_q.delete();
    idle(6);
    checks++; if (obs_q.size() != 0 || credits !== c0 + 3) begin
      errors++; $display("FAIL masked_credits: got credits=%0d extra=%0d want credits=3 extra=0", credits - c0, obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_addr_wrap();
    int c0, t; bit ok; beat_t e, o;
    c0 = credits;
    drive(1, 1, 0, 0, 31'h7FFF8, 2, 64'h11112222_33334444, 8'hFF);
    drive(1, 1, 0, 0, 31'h0, 0, 64'h55556666_77778888, 8'hFF);
    idle(10);
    t = cyc;
    drive(1, 0, 2, 3, 31'h7FFF8, 2, 64'h0, 8'h0);
    exp_q.push_back('{4'd2, 4'd3, 64'h11112222_33334444, t + 2 + LATENCY, 1'b0});
    exp_q.push_back('{4'd2, 4'd3, 64'h55556666_77778888, t + 3 + LATENCY, 1'b1});
    idle(10);
    t = cyc;
    drive(1, 0, 1, 0, 31'h0, 1, 64'h0, 8'h0);
    exp_q.push_back('{4'd1, 4'd0, 64'h55556666_77778888, t + 2 + LATENCY, 1'b1});
    idle(1);
    wait_beats(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d beats want 3", obs_q.size()); end
    else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != e.cyc || o.cr !== e.cr) begin
          errors++; $display("FAIL wrap_rd: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                             o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, e.cyc, e.cr);
        end
      end
    end
    exp_q.delete();
    idle(4);
    checks++; if (credits !== c0 + 3) begin errors++; $display("FAIL wrap_credits: got %0d want 3", credits - c0); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_read();
    int c0, t; bit ok; beat_t e, o;
    c0 = credits;
    drive(1, 0, 6, 0, 31'h40, 1, 64'h0, 8'h0);
    idle(2);
    Nrst = 1'b0;
    #1;
    checks++; if (fsabi_valid !== 1'b0 || fsabo_credit !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got valid=%b credit=%b want 0 0", fsabi_valid, fsabo_credit);
    end
    @(posedge clk); @(posedge clk); #1;
    Nrst = 1'b1;
    idle(12);
    checks++; if (obs_q.size() != 0 || credits !== c0) begin
      errors++; $display("FAIL midrst_abandon: got beats=%0d credits=%0d want 0 0", obs_q.size(), credits - c0);
    end
    obs_q.delete();
    t = cyc;
    drive(1, 0, 6, 2, 31'h40, 1, 64'h0, 8'h0);
    exp_q.push_back('{4'd6, 4'd2, 64'hDEADBEEF_CAFEF00D, t + 2 + LATENCY, 1'b1});
    idle(1);
    wait_beats(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: got %0d beats want 1", obs_q.size()); end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != e.cyc || o.cr !== e.cr) begin
        errors++; $display("FAIL midrst_rd: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                           o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, e.cyc, e.cr);
      end
    end
    exp_q.delete();
    idle(4);
    obs_q.delete();
  endtask

  task automatic test_credit_exhaust();
    int c0, t; bit ok; beat_t e, o;
    c0 = credits;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL exhaust_err_before: got %b want 0", err); end
    t = cyc;
    for (int i = 0; i <= CREDITS; i++) begin
      drive(1, 0, 4'(i), 4'(i), 31'h40, 1, 64'h0, 8'h0);
      if (i < CREDITS) exp_q.push_back('{4'(i), 4'(i), 64'hDEADBEEF_CAFEF00D, t + (2 + LATENCY) * (i + 1), 1'b1});
    end
    idle(1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL exhaust_err: got %b want 1", err); end
    wait_beats(CREDITS, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL exhaust_timeout: got %0d beats want %0d", obs_q.size(), CREDITS); end
    else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != e.cyc || o.cr !== e.cr) begin
          errors++; $display("FAIL exhaust_rd: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                             o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, e.cyc, e.cr);
        end
      end
    end
    exp_q.delete();
    idle(20);
    checks++; if (obs_q.size() != 0 || credits !== c0 + CREDITS) begin
      errors++; $display("FAIL exhaust_credits: got credits=%0d extra=%0d want credits=%0d extra=0", credits - c0, obs_q.size(), CREDITS);
    end
    obs_q.delete();
  endtask

  task automatic test_illegal_len();
    int c0, t; bit ok; beat_t e, o;
    logic [3:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int j = 0; j < 2; j++) begin
      Nrst = 1'b0;
      @(posedge clk); #1;
      Nrst = 1'b1;
      idle(1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_cleared len=%0d: got %b want 0", bad[j], err); end
      c0 = credits;
      drive(1, 0, 0, 0, 31'h40, bad[j], 64'h0, 8'h0);
      idle(2);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err len=%0d: got %b want 1", bad[j], err); end
      idle(12);
      checks++; if (obs_q.size() != 0 || credits !== c0) begin
        errors++; $display("FAIL illegal_dropped len=%0d: got beats=%0d credits=%0d want 0 0", bad[j], obs_q.size(), credits - c0);
      end
      obs_q.delete();
      t = cyc;
      drive(1, 0, 7, 4'(j), 31'h40, 1, 64'h0, 8'h0);
      exp_q.push_back('{4'd7, 4'(j), 64'hDEADBEEF_CAFEF00D, t + 2 + LATENCY, 1'b1});
      idle(1);
      wait_beats(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL illegal_timeout: got %0d beats want 1", obs_q.size()); end
      else begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o.data !== e.data || o.did !== e.did || o.sub !== e.sub || o.cyc != e.cyc || o.cr !== e.cr) begin
          errors++; $display("FAIL illegal_follow_rd: got did=%0d sub=%0d data=%h cyc=%0d cr=%b want did=%0d sub=%0d data=%h cyc=%0d cr=%b",
                             o.did, o.sub, o.data, o.cyc, o.cr, e.did, e.sub, e.data, e.cyc, e.cr);
        end
      end
      exp_q.delete();
      idle(4);
      checks++; if (credits !== c0 + 1) begin errors++; $display("FAIL illegal_credits: got %0d want 1", credits - c0); end
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_masked_burst();
    test_addr_wrap();
    test_reset_mid_read();
    test_credit_exhaust();
    test_illegal_len();
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_data_zero: got %0d nonzero idle cycles want 0", idle_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
